img_frame_buf: RTL and testbench

//  Receiving end of the pixel stream: captures a byte stream (din, din_vld) into an on-chip
//  IMG_W x IMG_H frame buffer in raster order. Pulses frame_done when full; the CNN front-end

---
 rtl/img_frame_buf_pkg.sv | 18 +
 rtl/img_ram_sdp.sv | 34 +++
 rtl/img_frame_buf.sv | 122 ++++++++++++
 tb/tb_img_frame_buf.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/img_frame_buf_pkg.sv
// Shared definitions for the pixel capture path: default frame geometry and capture FSM states.
// The image source uses these same constants.
package img_frame_buf_pkg;

  localparam int DEF_IMG_W  = 28;
  localparam int DEF_IMG_H  = 28;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 10;
  localparam int TOTAL_BYTES = DEF_IMG_W * DEF_IMG_H;
  localparam int POS_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_FULL    = 2'd2
  } frame_state_t;

endpackage

// File: rtl/img_ram_sdp.sv
// Simple dual-port frame RAM: one write port and one registered, read-first read port.
// Reads beyond DEPTH return zero.
module img_ram_sdp #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 784
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Separate process from the write so a same-address access sees the old word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      if (rd_addr < ADDR_W'(DEPTH)) rd_data <= mem[rd_addr];
      else                          rd_data <= '0;
    end
  end

endmodule

// File: rtl/img_frame_buf.sv
// Captures a raster-order pixel stream into an on-chip frame buffer and serves
// random-access reads to the CNN front-end.
module img_frame_buf
  import img_frame_buf_pkg::*;
#(
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] din,
  input  logic              din_vld,
  output logic              busy,
  output logic              frame_ready,
  output logic              frame_done,
  output logic              overflow,
  output logic [POS_W-1:0]  wr_row,
  output logic [POS_W-1:0]  wr_col,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_dout,
  output logic              rd_vld
);

  localparam int TOTAL = IMG_W * IMG_H;

  frame_state_t      state, state_nxt;
  logic [ADDR_W-1:0] wr_addr, addr_nxt;
  logic [POS_W-1:0]  row_nxt, col_nxt;
  logic              ready_nxt, done_nxt, ovf_nxt, wr_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      wr_addr     <= '0;
      wr_row      <= '0;
      wr_col      <= '0;
      frame_ready <= 1'b0;
      frame_done  <= 1'b0;
      overflow    <= 1'b0;
      rd_vld      <= 1'b0;
    end else begin
      state       <= state_nxt;
      wr_addr     <= addr_nxt;
      wr_row      <= row_nxt;
      wr_col      <= col_nxt;
      frame_ready <= ready_nxt;
      frame_done  <= done_nxt;
      overflow    <= ovf_nxt;
      rd_vld      <= rd_en;
    end
  end

  // start overrides everything, including a pixel arriving in the same cycle.
  always_comb begin
    state_nxt = state;
    addr_nxt  = wr_addr;
    row_nxt   = wr_row;
    col_nxt   = wr_col;
    ready_nxt = frame_ready;
    done_nxt  = 1'b0;
    ovf_nxt   = overflow;
    wr_en     = 1'b0;
    if (start) begin
      state_nxt = ST_CAPTURE;
      addr_nxt  = '0;
      row_nxt   = '0;
      col_nxt   = '0;
      ready_nxt = 1'b0;
      ovf_nxt   = 1'b0;
    end else begin
      case (state)
        ST_CAPTURE: begin
          if (din_vld) begin
            wr_en = 1'b1;
            if (wr_addr == ADDR_W'(TOTAL - 1)) begin
              state_nxt = ST_FULL;
              addr_nxt  = '0;
              row_nxt   = '0;
              col_nxt   = '0;
              ready_nxt = 1'b1;
              done_nxt  = 1'b1;
            end else begin
              addr_nxt = wr_addr + 1'b1;
              if (wr_col == POS_W'(IMG_W - 1)) begin
                col_nxt = '0;
                row_nxt = wr_row + 1'b1;
              end else begin
                col_nxt = wr_col + 1'b1;
              end
            end
          end
        end
        ST_FULL: begin
          if (din_vld) ovf_nxt = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == ST_CAPTURE);

  img_ram_sdp #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (TOTAL)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (din),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_dout)
  );

endmodule

// File: tb/tb_img_frame_buf.sv
// Directed bench for img_frame_buf: frame capture, readback table, restart, overflow and reset.
module tb_img_frame_buf;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] din = '0;
  logic       din_vld = 1'b0;
  logic       busy, frame_ready, frame_done, overflow;
  logic [4:0] wr_row, wr_col;
  logic       rd_en = 1'b0;
  logic [9:0] rd_addr = '0;
  logic [7:0] rd_dout;
  logic       rd_vld;

  int n_chk = 0;
  int n_pass = 0;
  int done_cnt = 0;
  int base;

  typedef struct {
    logic [9:0] addr;
    logic [7:0] data;
  } rd_vec_t;
  rd_vec_t rd_tab[8];

  img_frame_buf dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .din         (din),
    .din_vld     (din_vld),
    .busy        (busy),
    .frame_ready (frame_ready),
    .frame_done  (frame_done),
    .overflow    (overflow),
    .wr_row      (wr_row),
    .wr_col      (wr_col),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_dout     (rd_dout),
    .rd_vld      (rd_vld)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (frame_done) done_cnt <= done_cnt + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic push(input logic [7:0] d, input int gap);
    din = d;
    din_vld = 1'b1;
    tick();
    din_vld = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic read_chk(input string name, input logic [9:0] a, input logic [7:0] exp);
    rd_en = 1'b1;
    rd_addr = a;
    tick();
    rd_en = 1'b0;
    check({name, " data"}, int'(rd_dout), int'(exp));
    check({name, " vld"}, int'(rd_vld), 1);
  endtask

  initial begin
    rd_tab[0] = '{10'd0,   8'h00};
    rd_tab[1] = '{10'd27,  8'h1B};
    rd_tab[2] = '{10'd28,  8'h1C};
    rd_tab[3] = '{10'd783, 8'h0F};
    rd_tab[4] = '{10'd800, 8'h00};
    rd_tab[5] = '{10'd255, 8'hFF};
    rd_tab[6] = '{10'd256, 8'h00};
    rd_tab[7] = '{10'd500, 8'hF4};

    // reset state
    #12;
    check("rst busy", int'(busy), 0);
    check("rst ready", int'(frame_ready), 0);
    check("rst done", int'(frame_done), 0);
    check("rst ovf", int'(overflow), 0);
    check("rst row", int'(wr_row), 0);
    check("rst col", int'(wr_col), 0);
    check("rst rd_vld", int'(rd_vld), 0);
    rst_n = 1'b1;
    tick();

    // 1: spaced capture
    pulse_start();
    check("t1 busy", int'(busy), 1);
    base = done_cnt;
    for (int i = 0; i < 784; i++) begin
      push(i[7:0], 0);
      if (i == 0) check("t1 col after px0", int'(wr_col), 1);
      if (i == 27) begin
        check("t1 row after px27", int'(wr_row), 1);
        check("t1 col after px27", int'(wr_col), 0);
      end
      if (i == 782) check("t1 no early done", int'(frame_done), 0);
      if (i == 783) check("t1 done pulse", int'(frame_done), 1);
      else repeat (12) tick();
    end
    check("t1 ready", int'(frame_ready), 1);
    check("t1 busy", int'(busy), 0);
    check("t1 row", int'(wr_row), 0);
    check("t1 col", int'(wr_col), 0);
    tick();
    check("t1 done low", int'(frame_done), 0);
    check("t1 done count", done_cnt - base, 1);

    // 2: readback table
    for (int k = 0; k < 8; k++) read_chk($sformatf("t2 rd[%0d]", rd_tab[k].addr), rd_tab[k].addr, rd_tab[k].data);
    read_chk("t2 pre-hold", 10'd27, 8'h1B);
    tick();
    check("t2 hold data", int'(rd_dout), 8'h1B);
    check("t2 hold vld", int'(rd_vld), 0);

    // 3: back-to-back capture
    pulse_start();
    base = done_cnt;
    for (int i = 0; i < 784; i++) begin
      push(i[7:0], 0);
      if (i == 28) begin
        check("t3 row after px28", int'(wr_row), 1);
        check("t3 col after px28", int'(wr_col), 1);
      end
    end
    tick();
    check("t3 done count", done_cnt - base, 1);
    for (int k = 0; k < 8; k++) read_chk($sformatf("t3 rd[%0d]", rd_tab[k].addr), rd_tab[k].addr, rd_tab[k].data);

    // 4: overflow in FULL
    push(8'hAA, 0);
    check("t4 ovf", int'(overflow), 1);
    check("t4 ready", int'(frame_ready), 1);
    check("t4 row", int'(wr_row), 0);
    read_chk("t4 mem0", 10'd0, 8'h00);
    read_chk("t4 mem1", 10'd1, 8'h01);
    pulse_start();
    check("t4 ovf clr", int'(overflow), 0);
    check("t4 ready clr", int'(frame_ready), 0);
    check("t4 busy", int'(busy), 1);

    // 5: abandoned partial frame, restart with colliding pixel
    base = done_cnt;
    for (int i = 0; i < 100; i++) push(8'h55, 0);
    check("t5 partial no done", done_cnt - base, 0);
    din = 8'h77;
    din_vld = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    din_vld = 1'b0;
    check("t5 restart col", int'(wr_col), 0);
    check("t5 restart row", int'(wr_row), 0);
    for (int i = 0; i < 784; i++) begin
      if (i == 50) begin
        rd_en = 1'b1;
        rd_addr = 10'd50;
      end
      push(8'(i + 3), 0);
      if (i == 50) begin
        rd_en = 1'b0;
        check("t5 read-first", int'(rd_dout), 8'h55);
      end
    end
    tick();
    check("t5 done count", done_cnt - base, 1);
    read_chk("t5 mem0", 10'd0, 8'h03);
    read_chk("t5 mem50", 10'd50, 8'h35);
    read_chk("t5 mem99", 10'd99, 8'h66);
    read_chk("t5 mem783", 10'd783, 8'h12);

    // 6: async reset mid-capture
    pulse_start();
    for (int i = 0; i < 400; i++) push(8'(i), 0);
    check("t6 row", int'(wr_row), 14);
    check("t6 col", int'(wr_col), 8);
    read_chk("t6 pre rd", 10'd1, 8'h01);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6 busy", int'(busy), 0);
    check("t6 row0", int'(wr_row), 0);
    check("t6 col0", int'(wr_col), 0);
    check("t6 rd_vld", int'(rd_vld), 0);
    check("t6 rd_dout", int'(rd_dout), 0);
    check("t6 ready", int'(frame_ready), 0);
    tick();
    rst_n = 1'b1;
    tick();
    push(8'h99, 0);
    push(8'h98, 0);
    check("t6 ignored busy", int'(busy), 0);
    check("t6 ignored col", int'(wr_col), 0);
    check("t6 ignored ovf", int'(overflow), 0);
    pulse_start();
    push(8'hC3, 0);
    check("t6 rearm col", int'(wr_col), 1);
    read_chk("t6 rearm mem0", 10'd0, 8'hC3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
